// File: rtl/add_serial_pkg.sv
// Shared types and constants for the bit-serial adder and its front-end sequencer.
package add_serial_pkg;

  localparam int ADD_W           = 8;
  localparam int ADD_LAT_DEFAULT = 9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RELEASE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/add_serial_seq_if.sv
// Bundle of the operand stream, adder pins, result stream and debug taps of add_serial_seq.
interface add_serial_seq_if;
  import add_serial_pkg::*;

  // Both streams use strict valid/ready: a beat transfers on a rising clk edge
  // where valid && ready; the source holds valid and data stable until then,
  // and valid never depends combinationally on ready.
  logic             in_valid;
  logic             in_ready;
  logic [ADD_W-1:0] in_a;
  logic [ADD_W-1:0] in_b;

  logic [ADD_W-1:0] add_a;
  logic [ADD_W-1:0] add_b;
  logic             add_en;
  logic [ADD_W-1:0] add_out;

  logic             res_valid;
  logic             res_ready;
  logic [ADD_W-1:0] res_sum;

  logic             busy;
  seq_state_t       state_dbg;
  logic [7:0]       fifo_level;

  modport master (
    input  in_valid, in_a, in_b, add_out, res_ready,
    output in_ready, add_a, add_b, add_en, res_valid, res_sum, busy,
           state_dbg, fifo_level
  );

  modport slave (
    output in_valid, in_a, in_b, add_out, res_ready,
    input  in_ready, add_a, add_b, add_en, res_valid, res_sum, busy,
           state_dbg, fifo_level
  );

endinterface

// File: rtl/add_serial_seq_fifo.sv
// Operand-pair FIFO; full is registered so the upstream ready is a flop output.
module add_serial_seq_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_next;
  logic          full_q;
  logic          do_push;
  logic          do_pop;

  // A push offered while full is dropped, so stored data is never overwritten.
  assign do_push    = push && !full_q;
  assign do_pop     = pop && (count_q != '0);
  assign count_next = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count_q <= count_next;
      full_q  <= (count_next == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = full_q;
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/add_serial_seq.sv
// Sequencer in front of add_serial: buffers operand pairs, pulses the adder start/release,
// waits out the serial latency and holds the captured sum on a valid/ready result port.
module add_serial_seq
  import add_serial_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int ADD_LAT = ADD_LAT_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  add_serial_seq_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ADD_LAT);
  // START and the timer==0 WAIT cycle account for the two cycles not counted down.
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ADD_LAT - 2);

  seq_state_t         state;
  seq_state_t         state_next;
  logic [TW-1:0]      timer;
  logic               res_valid_q;
  logic [ADD_W-1:0]   res_sum_q;

  logic [2*ADD_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [AW:0]        fifo_count;
  logic               fifo_pop;

  logic               add_en;
  logic [ADD_W-1:0]   add_a;
  logic [ADD_W-1:0]   add_b;
  logic               res_hs;

  add_serial_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (2*ADD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (fifo_pop),
    .wdata ({bus.in_a, bus.in_b}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign res_hs = res_valid_q && bus.res_ready;

  always_comb begin
    state_next = state;
    add_en     = 1'b0;
    add_a      = '0;
    add_b      = '0;
    fifo_pop   = 1'b0;
    case (state)
      S_IDLE: begin
        // A result being accepted this cycle frees the output register in time.
        if (!fifo_empty && (!res_valid_q || res_hs)) state_next = S_START;
      end
      S_START: begin
        add_en     = 1'b1;
        add_a      = fifo_rdata[2*ADD_W-1:ADD_W];
        add_b      = fifo_rdata[ADD_W-1:0];
        fifo_pop   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (timer == '0) state_next = S_CAPTURE;
      end
      S_CAPTURE: state_next = S_RELEASE;
      S_RELEASE: begin
        add_en     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
    end else begin
      state <= state_next;
      if (state == S_START) begin
        timer <= TIMER_LOAD;
      end else if (state == S_WAIT && timer != '0) begin
        timer <= timer - TW'(1);
      end
      if (state == S_CAPTURE) begin
        res_sum_q   <= bus.add_out;
        res_valid_q <= 1'b1;
      end else if (res_hs) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = !fifo_full;
  assign bus.add_en     = add_en;
  assign bus.add_a      = add_a;
  assign bus.add_b      = add_b;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_sum    = res_sum_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.state_dbg  = state;
  assign bus.fifo_level = 8'(fifo_count);

endmodule
